// File: rtl/mac_seq_ctrl_if.sv
// Bundle of the command, operand-RAM, mac_unit and result signals around mac_seq_ctrl.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface mac_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_a_base;
    logic [ADDR_WIDTH-1:0] cmd_b_base;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [ADDR_WIDTH-1:0] ram_a_addr;
    logic [ADDR_WIDTH-1:0] ram_b_addr;
    logic                  ram_rd_en;
    logic [DATA_WIDTH-1:0] ram_a_data;
    logic [DATA_WIDTH-1:0] ram_b_data;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic                  mac_enable;
    logic                  mac_accumulate;
    logic [ACC_WIDTH-1:0]  mac_result;
    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_WIDTH-1:0]  res_data;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_a_base, cmd_b_base, cmd_len,
        input  ram_a_data, ram_b_data, mac_result, res_ready,
        output cmd_ready, ram_a_addr, ram_b_addr, ram_rd_en,
        output mac_a, mac_b, mac_enable, mac_accumulate,
        output res_valid, res_data, busy
    );

    modport master (
        output cmd_valid, cmd_a_base, cmd_b_base, cmd_len,
        output ram_a_data, ram_b_data, mac_result, res_ready,
        input  cmd_ready, ram_a_addr, ram_b_addr, ram_rd_en,
        input  mac_a, mac_b, mac_enable, mac_accumulate,
        input  res_valid, res_data, busy
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams operand pairs from two 1-cycle RAMs into mac_unit,
// waits for the MAC pipeline to drain, then presents the sum on a valid/ready port.
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8,
    parameter int MAC_LAT    = 2
) (
    input logic           clk,
    input logic           rst_n,
    mac_seq_ctrl_if.slave bus
);
    localparam int DCW = $clog2(MAC_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remain_q;
    logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q;
    logic [DCW-1:0]        drain_q;
    logic                  rd_en_q, first_q, en_q, acc_q;
    logic [ACC_WIDTH-1:0]  res_q;
    logic                  cmd_fire, drain_done;

    assign cmd_fire   = bus.cmd_valid && (state_q == IDLE);
    assign drain_done = (state_q == DRAIN) && (drain_q == DCW'(MAC_LAT));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cmd_fire) state_d = (bus.cmd_len == '0) ? DONE : ISSUE;
            ISSUE: if (remain_q == '0) state_d = DRAIN;
            DRAIN: if (drain_done) state_d = DONE;
            DONE:  if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // remain_q counts elements still to issue after the current one, so the
    // last read is the cycle where it reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_addr_q <= '0;
            b_addr_q <= '0;
            remain_q <= '0;
            drain_q  <= '0;
            rd_en_q  <= 1'b0;
            first_q  <= 1'b0;
            en_q     <= 1'b0;
            acc_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            // RAM data lands one cycle after the read, so enable/accumulate trail it by one.
            en_q  <= rd_en_q;
            acc_q <= rd_en_q && !first_q;
            case (state_q)
                IDLE: if (cmd_fire) begin
                    a_addr_q <= bus.cmd_a_base;
                    b_addr_q <= bus.cmd_b_base;
                    remain_q <= bus.cmd_len - 1'b1;
                    first_q  <= 1'b1;
                    rd_en_q  <= (bus.cmd_len != '0);
                    drain_q  <= '0;
                    res_q    <= '0;
                end
                ISSUE: begin
                    if (remain_q == '0) begin
                        rd_en_q <= 1'b0;
                    end else begin
                        a_addr_q <= a_addr_q + 1'b1;
                        b_addr_q <= b_addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        first_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_done) res_q <= bus.mac_result;
                    else            drain_q <= drain_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready      = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.res_valid      = (state_q == DONE);
    assign bus.res_data       = res_q;
    assign bus.ram_a_addr     = a_addr_q;
    assign bus.ram_b_addr     = b_addr_q;
    assign bus.ram_rd_en      = rd_en_q;
    assign bus.mac_a          = bus.ram_a_data;
    assign bus.mac_b          = bus.ram_b_data;
    assign bus.mac_enable     = en_q;
    assign bus.mac_accumulate = acc_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with behavioural operand RAMs and a 2-stage mac_unit model;
// expected sums are queued when commands are sent and checked when results appear.
module tb_mac_seq_ctrl;
    localparam int DW = 8, AW = 32, ADW = 10, LW = 8, LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .LEN_WIDTH(LW)) bus ();

    mac_seq_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .LEN_WIDTH(LW),
                   .MAC_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic signed [DW-1:0] mem_a [0:1023];
    logic signed [DW-1:0] mem_b [0:1023];

    always @(posedge clk) begin
        if (bus.ram_rd_en) begin
            bus.ram_a_data <= mem_a[bus.ram_a_addr];
            bus.ram_b_data <= mem_b[bus.ram_b_addr];
        end
    end

    // mac_unit model: product registered on the enable edge, accumulated one edge later
    logic signed [AW-1:0] m_p, m_acc;
    logic m_en, m_accf;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_p <= '0; m_acc <= '0; m_en <= 1'b0; m_accf <= 1'b0;
        end else begin
            m_p    <= 32'($signed(bus.mac_a)) * 32'($signed(bus.mac_b));
            m_en   <= bus.mac_enable;
            m_accf <= bus.mac_accumulate;
            if (m_en) m_acc <= m_accf ? m_acc + m_p : m_p;
        end
    end
    assign bus.mac_result = m_acc;

    int checks = 0, failures = 0;
    int exp_q[$];
    logic acc_log[$];
    int rd_cnt = 0;

    always @(negedge clk) begin
        if (bus.mac_enable) acc_log.push_back(bus.mac_accumulate);
        if (bus.ram_rd_en) rd_cnt++;
    end

    task automatic send_cmd(input int ab, input int bb, input int len);
        int s;
        s = 0;
        for (int k = 0; k < len; k++)
            s += int'(mem_a[(ab + k) % 1024]) * int'(mem_b[(bb + k) % 1024]);
        exp_q.push_back(s);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_a_base = ADW'(ab);
        bus.cmd_b_base = ADW'(bb);
        bus.cmd_len    = LW'(len);
        for (int t = 0; t < 200; t++) begin
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // cyc counts cycles from the accept cycle; -1 on timeout
    task automatic wait_result(output int data, output int cyc);
        data = 0;
        cyc = -1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                data = int'(bus.res_data);
                cyc = c;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_busy_valid got=%b%b exp=00", bus.busy, bus.res_valid); end
        checks++; if (bus.ram_rd_en !== 1'b0 || bus.mac_enable !== 1'b0 || bus.mac_accumulate !== 1'b0) begin
            failures++; $display("FAIL reset_strobes got=%b%b%b exp=000", bus.ram_rd_en, bus.mac_enable, bus.mac_accumulate); end
        checks++; if (bus.ram_a_addr !== '0 || bus.ram_b_addr !== '0 || bus.res_data !== '0) begin
            failures++; $display("FAIL reset_data a=%0d b=%0d res=%0d exp=0", bus.ram_a_addr, bus.ram_b_addr, bus.res_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int d, c, e;
        send_cmd(0, 512, 1);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== 15 || e !== 15) begin failures++; $display("FAIL single_data got=%0d exp=15", d); end
        checks++; if (c !== 1 + LAT + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", c, 1 + LAT + 2); end
        @(posedge clk); #1;
    endtask

    task automatic test_accumulate();
        int d, c, e, n0;
        n0 = acc_log.size();
        send_cmd(16, 528, 4);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== e || e !== 14) begin failures++; $display("FAIL dot4_data got=%0d exp=14", d); end
        checks++; if (c !== 4 + LAT + 2) begin failures++; $display("FAIL dot4_latency got=%0d exp=%0d", c, 4 + LAT + 2); end
        checks++;
        if (acc_log.size() - n0 !== 4 || acc_log[n0] !== 1'b0 || acc_log[n0+1] !== 1'b1 ||
            acc_log[n0+2] !== 1'b1 || acc_log[n0+3] !== 1'b1) begin
            failures++; $display("FAIL dot4_acc_pattern enables=%0d exp=4 pattern exp=0111", acc_log.size() - n0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        int d, c, e;
        send_cmd(32, 544, 1);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== e || d !== 32'hFFFFFFCE) begin failures++; $display("FAIL signed_neg got=%h exp=ffffffce", d); end
        @(posedge clk); #1;
        send_cmd(40, 552, 3);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== e || d !== 48387) begin failures++; $display("FAIL max_pos got=%0d exp=48387", d); end
        @(posedge clk); #1;
        // address walk wraps past the top of the RAM
        send_cmd(1022, 1022, 4);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL addr_wrap got=%0d exp=%0d", d, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_len_zero();
        int d, c, e, r0;
        r0 = rd_cnt;
        send_cmd(100, 600, 0);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== e || d !== 0) begin failures++; $display("FAIL len0_data got=%0d exp=0", d); end
        checks++; if (c !== 1) begin failures++; $display("FAIL len0_latency got=%0d exp=1", c); end
        checks++; if (rd_cnt !== r0) begin failures++; $display("FAIL len0_rd_en got=%0d exp=0", rd_cnt - r0); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int d, c, e;
        bus.res_ready = 1'b0;
        send_cmd(40, 552, 2);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== e || d !== 32258) begin failures++; $display("FAIL bp_data got=%0d exp=32258", d); end
        bus.cmd_valid = 1'b1;
        bus.cmd_len = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.res_valid !== 1'b1 || int'(bus.res_data) !== e) begin
                failures++; $display("FAIL bp_hold cyc=%0d valid=%b data=%0d exp valid=1 data=%0d", i, bus.res_valid, bus.res_data, e); end
            checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready cyc=%0d got=%b exp=0", i, bus.cmd_ready); end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release valid=%b ready=%b exp=0,1", bus.res_valid, bus.cmd_ready); end
    endtask

    task automatic test_reset_mid();
        int d, c, e;
        send_cmd(64, 576, 8);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.ram_rd_en !== 1'b1 || bus.ram_a_addr !== ADW'(66)) begin
            failures++; $display("FAIL mid_issue_k2 rd_en=%b addr=%0d exp=1,66", bus.ram_rd_en, bus.ram_a_addr); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_state ready=%b busy=%b valid=%b exp=1,0,0", bus.cmd_ready, bus.busy, bus.res_valid); end
        checks++; if (bus.ram_rd_en !== 1'b0 || bus.mac_enable !== 1'b0 || bus.ram_a_addr !== '0 || bus.res_data !== '0) begin
            failures++; $display("FAIL mid_reset_outputs rd=%b en=%b addr=%0d res=%0d exp=0", bus.ram_rd_en, bus.mac_enable, bus.ram_a_addr, bus.res_data); end
        rst_n = 1'b1;
        send_cmd(17, 529, 2);
        wait_result(d, c);
        e = exp_q.pop_front();
        checks++; if (d !== e || d !== 5) begin failures++; $display("FAIL after_reset_data got=%0d exp=5", d); end
        checks++; if (c !== 2 + LAT + 2) begin failures++; $display("FAIL after_reset_latency got=%0d exp=%0d", c, 2 + LAT + 2); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_a_base = '0; bus.cmd_b_base = '0; bus.cmd_len = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = DW'($urandom_range(0, 255));
            mem_b[i] = DW'($urandom_range(0, 255));
        end
        mem_a[0] = 8'sd5;  mem_b[512] = 8'sd3;
        for (int i = 0; i < 4; i++) begin
            mem_a[16+i] = DW'(i); mem_b[528+i] = DW'(i);
        end
        mem_a[32] = -8'sd10; mem_b[544] = 8'sd5;
        for (int i = 0; i < 3; i++) begin
            mem_a[40+i] = 8'sd127; mem_b[552+i] = 8'sd127;
        end
        test_reset();
        test_single();
        test_accumulate();
        test_signed();
        test_len_zero();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
